// File: rtl/bit_pair_multiplier_if.sv
// bit_pair_multiplier_if: handshake and operand/result bus for bit_pair_multiplier (start/signed_mode/multiplier/multiplicand from master, result/ready/done from slave; bit 0 is MSB)
interface bit_pair_multiplier_if #(parameter int WIDTH = 32);
  logic start;
  logic signed_mode;
  logic [0:WIDTH-1] multiplier;
  logic [0:WIDTH-1] multiplicand;
  logic [0:2*WIDTH-1] result;
  logic ready;
  logic done;
  modport master (output start, signed_mode, multiplier, multiplicand, input result, ready, done);
  modport slave (input start, signed_mode, multiplier, multiplicand, output result, ready, done);
endinterface

// File: rtl/bit_pair_multiplier.sv
// bit_pair_multiplier: radix-4 sequential signed/unsigned multiplier, WIDTH/2+2 cycle latency; ports clock, reset (sync, active-high), bus (slave: start/signed_mode/multiplier/multiplicand in, result/ready/done out)
module bit_pair_multiplier #(parameter int WIDTH = 32) (
  input logic clock,
  input logic reset,
  bit_pair_multiplier_if.slave bus
);
  if (WIDTH % 2 != 0 || WIDTH < 4) begin : g_width_check
    $error("bit_pair_multiplier: WIDTH must be even and >= 4");
  end
  localparam int AW = WIDTH + 4;
  localparam int CW = $clog2(WIDTH / 2 + 1);
  localparam logic [1:0] IDLE = 2'd0, ITER = 2'd1, FINISH = 2'd2;
  logic [1:0] state;
  logic [AW-1:0] acc;
  logic [WIDTH+1:0] m, q;
  logic [CW-1:0] cnt;
  logic carry;
  logic [2:0] v;
  logic [AW-1:0] mx, addend, sum;
  logic neg;
  assign v = {1'b0, q[1:0]} + {2'b00, carry};
  assign mx = {{2{m[WIDTH+1]}}, m};
  assign neg = v == 3'd3;
  assign addend = v == 3'd1 ? mx : v == 3'd2 ? mx << 1 : neg ? ~mx : '0;
  assign sum = acc + addend + AW'(neg);
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      m <= '0;
      q <= '0;
      cnt <= '0;
      carry <= 1'b0;
      bus.result <= '0;
      bus.ready <= 1'b1;
      bus.done <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          m <= bus.signed_mode ? {{2{bus.multiplier[0]}}, bus.multiplier} : {2'b00, bus.multiplier};
          q <= bus.signed_mode ? {{2{bus.multiplicand[0]}}, bus.multiplicand} : {2'b00, bus.multiplicand};
          acc <= '0;
          carry <= 1'b0;
          cnt <= CW'(WIDTH / 2);
          bus.ready <= 1'b0;
          state <= ITER;
        end
        ITER: begin
          acc <= {{2{sum[AW-1]}}, sum[AW-1:2]};
          q <= {sum[1:0], q[WIDTH+1:2]};
          carry <= v[2] | (v[1] & v[0]);
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= FINISH;
        end
        FINISH: begin
          bus.result <= {acc[WIDTH-3:0], q};
          bus.done <= 1'b1;
          bus.ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
